// File: rtl/add_responder_if.sv
// ============================================================================
// Module  : add_responder_if
// Brief   : Operand-pair request and sum response bundle for add_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface add_responder_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_a;
    logic [WIDTH-1:0]           in_b;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH:0]             out_sum;
    logic [CNT_W-1:0]           txn_count;
    logic [$clog2(DEPTH):0]     fifo_level;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, txn_count, fifo_level
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, txn_count, fifo_level
    );
endinterface

`default_nettype wire

// File: rtl/add_responder.sv
// ============================================================================
// Module  : add_responder
// Brief   : Accepts operand pairs, registers their zero-extended sum, and
//           returns results in order through a small FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module add_responder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    add_responder_if.slave     bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    logic               r_s1_valid;
    logic [WIDTH:0]     r_s1_sum;
    logic [WIDTH:0]     r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [CNT_W-1:0]   r_txn;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [c_lvl_w-1:0] w_occ;

    // Occupancy counts the in-flight stage so a push can never find the FIFO full.
    assign w_occ    = r_level + c_lvl_w'(r_s1_valid);
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_push   = r_s1_valid;
    assign w_pop    = bus.out_valid && bus.out_ready;

    assign bus.in_ready   = (w_occ < c_lvl_w'(DEPTH)) && rst_n;
    assign bus.out_valid  = (r_level != '0);
    assign bus.out_sum    = r_mem[r_rd_ptr];
    assign bus.txn_count  = r_txn;
    assign bus.fifo_level = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_txn      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sum <= {1'b0, bus.in_a} + {1'b0, bus.in_b};
            end

            if (w_push) begin
                r_mem[r_wr_ptr] <= r_s1_sum;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_txn    <= r_txn + CNT_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_add_responder.sv
// ============================================================================
// Module  : tb_add_responder
// Brief   : Directed self-checking bench for add_responder (WIDTH=4, DEPTH=4,
//           CNT_W=4 so the transaction counter wraps quickly).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_add_responder;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    add_responder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    add_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [WIDTH:0] exp_q [$];
        logic [WIDTH:0] got_sum;
        int             sent;
        int             rcvd;
        int             ready_drops;
        int             max_lvl;
        int             pops;
        logic [WIDTH-1:0] ra, rb;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b0;

        // Reset values
        #3;
        chk("rst_in_ready",   32'(bus.in_ready),   0);
        chk("rst_out_valid",  32'(bus.out_valid),  0);
        chk("rst_fifo_level", 32'(bus.fifo_level), 0);
        chk("rst_txn_count",  32'(bus.txn_count),  0);
        chk("rst_out_sum",    32'(bus.out_sum),    0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 1);

        // Single pair 7+9
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd7, 4'd9);
        tick();
        drive(1'b0, '0, '0);
        chk("single_lat_n", 32'(bus.out_valid), 0);
        tick();
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_sum",   32'(bus.out_sum),   16);
        tick();
        chk("single_txn",   32'(bus.txn_count), 1);
        chk("single_empty", 32'(bus.out_valid), 0);

        // Max operands 15+15
        drive(1'b1, 4'd15, 4'd15);
        tick();
        drive(1'b0, '0, '0);
        tick();
        chk("max_sum", 32'(bus.out_sum), 30);
        tick();
        chk("max_txn", 32'(bus.txn_count), 2);

        // Fill under backpressure
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, WIDTH'(k), WIDTH'(k));
            chk("fill_ready", 32'(bus.in_ready), 1);
            tick();
        end
        drive(1'b1, 4'd5, 4'd5);
        chk("fill_blocked", 32'(bus.in_ready), 0);
        tick();
        chk("fill_level",   32'(bus.fifo_level), 4);
        chk("fill_blocked2", 32'(bus.in_ready),  0);
        tick();
        chk("fill_hold",    32'(bus.fifo_level), 4);
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_sum", 32'(bus.out_sum), 32'(2 * k));
            tick();
        end
        chk("drain_ready", 32'(bus.in_ready),   1);
        chk("drain_empty", 32'(bus.fifo_level), 0);
        chk("drain_txn",   32'(bus.txn_count),  6);

        // Streaming 20 random pairs
        sent = 0; rcvd = 0; ready_drops = 0; max_lvl = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 20; cyc++) begin
            if (sent < 20) begin
                ra = WIDTH'($urandom_range(15, 0));
                rb = WIDTH'($urandom_range(15, 0));
                drive(1'b1, ra, rb);
                if (bus.in_ready) begin
                    exp_q.push_back({1'b0, ra} + {1'b0, rb});
                    sent++;
                end else begin
                    ready_drops++;
                end
            end else begin
                drive(1'b0, '0, '0);
            end
            if (bus.out_valid) begin
                got_sum = bus.out_sum;
                if (exp_q.size() == 0) chk("stream_spurious", 1, 0);
                else chk("stream_sum", 32'(got_sum), 32'(exp_q.pop_front()));
                rcvd++;
            end
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
            tick();
        end
        drive(1'b0, '0, '0);
        chk("stream_rcvd",   32'(rcvd),        20);
        chk("stream_drops",  32'(ready_drops), 0);
        chk("stream_lvl_le1", 32'(max_lvl <= 1), 1);
        chk("stream_txn",    32'(bus.txn_count), 10);

        // Reset while three results are queued
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd1, 4'd2);
            tick();
        end
        drive(1'b0, '0, '0);
        tick();
        chk("pre_rst_level", 32'(bus.fifo_level), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid),  0);
        chk("mid_rst_level", 32'(bus.fifo_level), 0);
        chk("mid_rst_txn",   32'(bus.txn_count),  0);
        tick();
        rst_n = 1'b1;
        #1;
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd6, 4'd3);
        tick();
        drive(1'b0, '0, '0);
        tick();
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_sum",   32'(bus.out_sum),   9);
        tick();
        chk("post_rst_txn",   32'(bus.txn_count), 1);

        // Counter wrap: 17 pops from zero
        do_reset();
        bus.out_ready = 1'b1;
        pops = 0;
        sent = 0;
        for (int cyc = 0; cyc < 40 && pops < 17; cyc++) begin
            logic popping;
            if (sent < 17) begin
                drive(1'b1, 4'd2, 4'd3);
                if (bus.in_ready) sent++;
            end else begin
                drive(1'b0, '0, '0);
            end
            popping = bus.out_valid && bus.out_ready;
            tick();
            if (popping) begin
                pops++;
                chk("wrap_txn", 32'(bus.txn_count), 32'(pops % 16));
            end
        end
        drive(1'b0, '0, '0);
        chk("wrap_pops",  32'(pops),          17);
        chk("wrap_final", 32'(bus.txn_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
